// File: rtl/bpu_ghr_index.sv
// bpu_ghr_index: gshare index generation, speculative/architectural history and checkpoint FIFO for a two-slot PHT
module bpu_ghr_index #(
  parameter int IDX_W = 8,
  parameter int CKPT_DEPTH = 8,
  localparam int PW = $clog2(CKPT_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_pc,
  output logic                  fetch_ready,
  output logic [1:0][IDX_W-1:0] index,
  input  logic [1:0]            br_mask,
  input  logic [1:0]            taken_or_not,
  output logic [1:0]            pred_taken,
  input  logic                  res_valid,
  input  logic                  res_taken,
  input  logic                  res_mispredict,
  input  logic                  ext_flush,
  output logic                  update_en,
  output logic [IDX_W-1:0]      index_up,
  output logic                  taken_actual,
  output logic [CW-1:0]         fifo_count
);
  logic [IDX_W-1:0] spec_ghr, arch_ghr, arch_nxt, g1, g2;
  logic [IDX_W-1:0] fifo [CKPT_DEPTH];
  logic [1:0][IDX_W-1:0] s1_idx;
  logic [PW-1:0] head, tail;
  logic [1:0] cnt_slot, n_push;
  logic s1_valid, pop, mis, clear, accept;
  logic unused_pc;
  assign unused_pc = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};
  // slot1 sits at pc+4, i.e. one above slot0 in the word-address field
  assign index[0] = fetch_pc[IDX_W+1:2] ^ spec_ghr;
  assign index[1] = (fetch_pc[IDX_W+1:2] + IDX_W'(1)) ^ spec_ghr;
  assign pred_taken[0] = s1_valid & br_mask[0] & taken_or_not[0];
  assign pred_taken[1] = s1_valid & br_mask[1] & taken_or_not[1] & ~pred_taken[0];
  assign cnt_slot[0] = s1_valid & br_mask[0];
  assign cnt_slot[1] = s1_valid & br_mask[1] & ~pred_taken[0];
  assign n_push = {1'b0, cnt_slot[0]} + {1'b0, cnt_slot[1]};
  assign pop = res_valid & (fifo_count != '0);
  assign mis = pop & res_mispredict;
  assign clear = mis | ext_flush;
  // leave room for the two pushes an in-flight packet may still make
  assign fetch_ready = (({1'b0, fifo_count} + {{(CW-1){1'b0}}, s1_valid, 1'b0}) <= (CW+1)'(CKPT_DEPTH - 2)) & ~clear;
  assign accept = fetch_valid & fetch_ready;
  assign arch_nxt = pop ? {arch_ghr[IDX_W-2:0], res_taken} : arch_ghr;
  assign g1 = cnt_slot[0] ? {spec_ghr[IDX_W-2:0], pred_taken[0]} : spec_ghr;
  assign g2 = cnt_slot[1] ? {g1[IDX_W-2:0], pred_taken[1]} : g1;
  always_ff @(posedge clk) begin
    if (|cnt_slot) fifo[tail] <= cnt_slot[0] ? s1_idx[0] : s1_idx[1];
    if (&cnt_slot) fifo[tail + PW'(1)] <= s1_idx[1];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_ghr     <= '0;
      arch_ghr     <= '0;
      s1_valid     <= 1'b0;
      s1_idx       <= '0;
      head         <= '0;
      tail         <= '0;
      fifo_count   <= '0;
      update_en    <= 1'b0;
      index_up     <= '0;
      taken_actual <= 1'b0;
    end else begin
      spec_ghr   <= clear ? arch_nxt : g2;
      arch_ghr   <= arch_nxt;
      s1_valid   <= accept;
      head       <= clear ? '0 : head + PW'(pop);
      tail       <= clear ? '0 : tail + PW'(n_push);
      fifo_count <= clear ? '0 : fifo_count + CW'(n_push) - CW'(pop);
      update_en  <= pop;
      if (accept) s1_idx <= index;
      if (pop) begin
        index_up     <= fifo[head];
        taken_actual <= res_taken;
      end
    end
  end
endmodule

// File: tb/tb_bpu_ghr_index.sv
// tb_bpu_ghr_index: directed stimulus, queue-based reference model checked every cycle, plus literal expectations
module tb_bpu_ghr_index;
  logic clk = 0, rst;
  logic fetch_valid, fetch_ready, res_valid, res_taken, res_mispredict, ext_flush;
  logic update_en, taken_actual;
  logic [31:0] fetch_pc;
  logic [1:0][7:0] index;
  logic [1:0] br_mask, taken_or_not, pred_taken;
  logic [7:0] index_up;
  logic [3:0] fifo_count;
  int tests = 0, fails = 0;

  bpu_ghr_index dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .index(index), .br_mask(br_mask), .taken_or_not(taken_or_not), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict), .ext_flush(ext_flush),
    .update_en(update_en), .index_up(index_up), .taken_actual(taken_actual), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  logic [7:0] m_spec = 0, m_arch = 0, m_idx_up = 0;
  logic [7:0] m_s1idx [2];
  logic [7:0] q [$];
  bit m_s1v = 0, m_upd = 0, m_tk = 0;

  function automatic logic [7:0] eidx(int s);
    logic [31:0] a;
    a = (fetch_pc + 32'(4 * s)) >> 2;
    return a[7:0] ^ m_spec;
  endfunction

  function automatic logic [1:0] epred();
    logic p0, p1;
    p0 = m_s1v && br_mask[0] && taken_or_not[0];
    p1 = m_s1v && br_mask[1] && taken_or_not[1] && !p0;
    return {p1, p0};
  endfunction

  function automatic logic eready();
    bit mis;
    mis = res_valid && res_mispredict && q.size() != 0;
    return (8 - q.size() - 2 * int'(m_s1v)) >= 2 && !mis && !ext_flush;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin : model
    logic [1:0] p;
    logic [7:0] g, n0, n1;
    bit acc, pop, mis;
    if (!rst) begin
      m_spec = 0; m_arch = 0; m_idx_up = 0; m_s1v = 0; m_upd = 0; m_tk = 0;
      q.delete();
    end else begin
      p = epred(); acc = fetch_valid && eready(); n0 = eidx(0); n1 = eidx(1);
      pop = res_valid && q.size() != 0;
      mis = pop && res_mispredict;
      g = m_spec;
      m_upd = pop;
      if (pop) begin
        m_idx_up = q.pop_front();
        m_tk = res_taken;
        m_arch = {m_arch[6:0], res_taken};
      end
      if (mis || ext_flush) begin
        m_spec = m_arch;
        q.delete();
      end else begin
        if (m_s1v)
          for (int s = 0; s < 2; s++)
            if (br_mask[s] && !(s == 1 && p[0])) begin
              g = {g[6:0], p[s]};
              q.push_back(m_s1idx[s]);
            end
        m_spec = g;
      end
      m_s1v = acc;
      if (acc) begin m_s1idx[0] = n0; m_s1idx[1] = n1; end
    end
  end

  always @(negedge clk) begin
    chk("index0", index[0], eidx(0));
    chk("index1", index[1], eidx(1));
    chk("fetch_ready", fetch_ready, eready());
    chk("fifo_count", fifo_count, q.size());
    chk("update_en", update_en, m_upd);
    chk("index_up", index_up, m_idx_up);
    chk("taken_actual", taken_actual, m_tk);
    if (m_s1v) chk("pred_taken", pred_taken, epred());
    if (rst && res_valid && q.size() == 0) begin
      tests++; fails++;
      $display("FAIL res_on_empty at %0t: res_valid=1 with fifo size 0, expected no resolve", $time);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  initial begin
    rst = 0; fetch_valid = 0; fetch_pc = 0; br_mask = 0; taken_or_not = 0;
    res_valid = 0; res_taken = 0; res_mispredict = 0; ext_flush = 0;
    repeat (2) @(posedge clk); #1;
    chk("lit_rst_update_en", update_en, 0);
    chk("lit_rst_fifo_count", fifo_count, 0);
    chk("lit_rst_index_up", index_up, 0);
    rst = 1;
    fetch_valid = 1; fetch_pc = 32'h1C000000; mid();
    chk("lit_idx0_first", index[0], 8'h00);
    chk("lit_idx1_first", index[1], 8'h01);
    chk("lit_ready_first", fetch_ready, 1);
    chk("lit_upd_first", update_en, 0);
    tick();
    fetch_valid = 0; br_mask = 2'b11; taken_or_not = 2'b01; mid();
    chk("lit_pred_01", pred_taken, 2'b01);
    tick();
    br_mask = 0; fetch_valid = 1; fetch_pc = 32'h1C000010; mid();
    chk("lit_count_one", fifo_count, 1);
    chk("lit_idx0_ghr1", index[0], 8'h05);
    chk("lit_idx1_ghr1", index[1], 8'h04);
    tick();
    fetch_valid = 0; br_mask = 2'b11; taken_or_not = 2'b00; tick();
    br_mask = 0; fetch_valid = 1; fetch_pc = 32'h1C000000; mid();
    chk("lit_idx0_ghr4", index[0], 8'h04);
    tick();
    fetch_valid = 0; br_mask = 2'b11; taken_or_not = 2'b10; mid();
    chk("lit_pred_10", pred_taken, 2'b10);
    tick();
    br_mask = 0; fetch_pc = 0; mid();
    chk("lit_idx0_ghr11", index[0], 8'h11);
    chk("lit_count_five", fifo_count, 5);
    tick();
    for (int i = 0; i < 5; i++) begin
      res_valid = 1; res_taken = (i >= 3); tick();
    end
    res_valid = 0; mid();
    chk("lit_drained", fifo_count, 0);
    chk("lit_drain_upd", update_en, 1);
    chk("lit_drain_idx", index_up, 8'h05);
    chk("lit_drain_tk", taken_actual, 1);
    tick();
    fetch_valid = 1; fetch_pc = 32'hEC; mid();
    chk("lit_idx_2a", index[0], 8'h2A);
    tick();
    br_mask = 2'b01; taken_or_not = 2'b00; fetch_pc = 32'h100; tick();
    br_mask = 2'b11; fetch_pc = 0; res_valid = 1; res_taken = 0; res_mispredict = 1; mid();
    chk("lit_ready_mis", fetch_ready, 0);
    tick();
    res_valid = 0; res_mispredict = 0; br_mask = 0; fetch_valid = 0; mid();
    chk("lit_mis_count", fifo_count, 0);
    chk("lit_mis_upd", update_en, 1);
    chk("lit_mis_idx", index_up, 8'h2A);
    chk("lit_mis_tk", taken_actual, 0);
    chk("lit_mis_ghr", index[0], 8'h06);
    tick();
    fetch_valid = 1; fetch_pc = 32'h40; tick();
    br_mask = 2'b11; tick(); tick();
    br_mask = 2'b01; tick();
    br_mask = 2'b11; tick();
    fetch_valid = 0; br_mask = 0; res_valid = 1; res_taken = 1; mid();
    chk("lit_full_ready", fetch_ready, 0);
    chk("lit_full_count", fifo_count, 7);
    tick();
    res_valid = 0; mid();
    chk("lit_pop_count", fifo_count, 6);
    chk("lit_pop_ready", fetch_ready, 1);
    tick();
    ext_flush = 1; res_valid = 1; res_taken = 0; tick();
    ext_flush = 0; res_valid = 0; mid();
    chk("lit_flush_count", fifo_count, 0);
    chk("lit_flush_ghr", index[0], 8'h0A);
    tick();
    fetch_valid = 1; tick();
    br_mask = 2'b11; tick(); tick();
    fetch_valid = 0; br_mask = 2'b01; tick();
    br_mask = 0; res_valid = 1; res_taken = 1; mid();
    chk("lit_five", fifo_count, 5);
    tick();
    res_valid = 0; #2 rst = 0; #1;
    chk("lit_async_upd", update_en, 0);
    chk("lit_async_count", fifo_count, 0);
    chk("lit_async_idx", index_up, 0);
    chk("lit_async_tk", taken_actual, 0);
    repeat (2) tick();
    rst = 1; mid();
    chk("lit_rel_ready", fetch_ready, 1);
    chk("lit_rel_count", fifo_count, 0);
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
